tinyalu_req_arbiter: RTL and testbench

- Two-requester front end that sequences the shared tinyalu datapath.
- Each requester submits an operation (op, A, B) over a valid/ready handshake.
- The block grants requesters round-robin and drives tinyalu's A/B/op/start.
- It holds start until done, then returns the 16-bit result on a per-requester valid/ready response channel, with an error flag for illegal opcodes.

---
 rtl/tinyalu_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_tinyalu_req_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_req_arbiter.sv
// Round-robin front end that lets two requesters share one tinyalu datapath.
// Define TINYALU_ARB_TIMEOUT_EN to abort an ISSUE that outlasts TIMEOUT_CYCLES.
module tinyalu_req_arbiter #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [5:0]       req_op,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [15:0]      rsp_result,
    output logic             rsp_err,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [15:0]      alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q;
    logic             rr_ptr_q;
    logic             gnt_q;
    logic [7:0]       alu_a_q;
    logic [7:0]       alu_b_q;
    logic [2:0]       alu_op_q;
    logic             alu_start_q;
    logic [1:0]       rsp_valid_q;
    logic [15:0]      rsp_result_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] op_count_q;

`ifdef TINYALU_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_q;
`endif

    logic       accept_d;
    logic       gnt_d;
    logic [2:0] op_d;
    logic [7:0] a_d;
    logic [7:0] b_d;

    function automatic logic op_legal(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Grant is decided combinationally so req_ready is visible in the accept cycle.
    always_comb begin
        accept_d  = (state_q == IDLE) && (req_valid != 2'b00);
        gnt_d     = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
        op_d      = gnt_d ? req_op[5:3]  : req_op[2:0];
        a_d       = gnt_d ? req_a[15:8]  : req_a[7:0];
        b_d       = gnt_d ? req_b[15:8]  : req_b[7:0];
        req_ready = 2'b00;
        if (accept_d) begin
            req_ready[gnt_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            gnt_q        <= 1'b0;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_op_q     <= 3'd0;
            alu_start_q  <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= 16'h0000;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
`ifdef TINYALU_ARB_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        gnt_q    <= gnt_d;
                        rr_ptr_q <= ~gnt_d;
                        if (op_legal(op_d)) begin
                            alu_a_q     <= a_d;
                            alu_b_q     <= b_d;
                            alu_op_q    <= op_d;
                            alu_start_q <= 1'b1;
                            state_q     <= ISSUE;
`ifdef TINYALU_ARB_TIMEOUT_EN
                            timer_q     <= TMR_W'(TIMEOUT_CYCLES);
`endif
                        end else begin
                            rsp_result_q <= 16'h0000;
                            rsp_err_q    <= 1'b1;
                            rsp_valid_q  <= gnt_d ? 2'b10 : 2'b01;
                            state_q      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    // A done arriving together with timer expiry still completes normally.
                    if (alu_done) begin
                        alu_start_q  <= 1'b0;
                        rsp_result_q <= alu_result;
                        rsp_err_q    <= 1'b0;
                        op_count_q   <= op_count_q + CNT_W'(1);
                        rsp_valid_q  <= gnt_q ? 2'b10 : 2'b01;
                        state_q      <= RESP;
                    end
`ifdef TINYALU_ARB_TIMEOUT_EN
                    else if (timer_q <= TMR_W'(1)) begin
                        alu_start_q  <= 1'b0;
                        rsp_result_q <= 16'h0000;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= gnt_q ? 2'b10 : 2'b01;
                        state_q      <= RESP;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_start  = alu_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tinyalu_req_arbiter.sv
// Bench for tinyalu_req_arbiter: directed scenarios plus random traffic against
// a transaction-level reference model and a behavioural tinyalu.
module tb_tinyalu_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        busy;
    logic [15:0] op_count;

    tinyalu_req_arbiter #(.CNT_W(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural tinyalu state
    bit alu_active, alu_hang, spur_en;
    int alu_cnt, alu_lat;

    // Reference model: one outstanding transaction at most
    bit          m_busy, m_done, m_g, m_rr, m_err;
    logic [15:0] m_res, m_cnt;
    logic [2:0]  m_op;
    logic [7:0]  m_a, m_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_reset();
        m_busy = 0; m_done = 0; m_rr = 0; m_cnt = 16'h0; m_g = 0; m_err = 0; m_res = 16'h0;
        alu_active = 0; alu_cnt = 0;
    endtask

    // One clock: drive the ALU model, compare against the model, advance it.
    task automatic step();
        logic [1:0] exp_rdy;
        logic       g;
        logic [2:0] op;
        logic [7:0] a, b;
        bit         legal;
        @(negedge clk);
        alu_done = 1'b0;
        if (!alu_start) begin
            alu_active = 0;
            if (spur_en && $urandom_range(0, 5) == 0) begin
                alu_done   = 1'b1;
                alu_result = 16'($urandom);
            end
        end else if (!alu_hang) begin
            if (!alu_active) begin
                alu_active = 1;
                alu_cnt    = alu_lat;
            end
            if (alu_cnt == 1) begin
                alu_done   = 1'b1;
                alu_result = ref_alu(alu_op, alu_a, alu_b);
            end
            if (alu_cnt != 0) alu_cnt--;
        end
        #1;
        g       = (req_valid == 2'b11) ? m_rr : req_valid[1];
        exp_rdy = (!m_busy && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
        op      = g ? req_op[5:3] : req_op[2:0];
        a       = g ? req_a[15:8] : req_a[7:0];
        b       = g ? req_b[15:8] : req_b[7:0];
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("rsp_valid", 32'(rsp_valid), (m_busy && m_done) ? (m_g ? 32'd2 : 32'd1) : 32'd0);
        if (m_busy && m_done) begin
            check_eq("rsp_result", 32'(rsp_result), 32'(m_res));
            check_eq("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        check_eq("alu_start", 32'(alu_start), 32'(m_busy && !m_done));
        if (m_busy && !m_done) begin
            check_eq("alu_a", 32'(alu_a), 32'(m_a));
            check_eq("alu_b", 32'(alu_b), 32'(m_b));
            check_eq("alu_op", 32'(alu_op), 32'(m_op));
        end
        check_eq("op_count", 32'(op_count), 32'(m_cnt));
        if (!m_busy) begin
            if (exp_rdy != 2'b00) begin
                legal  = (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
                m_busy = 1; m_g = g; m_rr = ~g;
                m_op = op; m_a = a; m_b = b;
                m_done = !legal; m_err = !legal;
                m_res  = legal ? ref_alu(op, a, b) : 16'h0000;
            end
        end else if (!m_done) begin
            if (alu_done) begin
                m_done = 1;
                m_cnt  = m_cnt + 16'd1;
            end
        end else if (rsp_ready[m_g]) begin
            m_busy = 0;
            m_done = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00; req_op = 6'h0; req_a = 16'h0; req_b = 16'h0;
        rsp_ready = 2'b00; alu_done = 1'b0; alu_result = 16'h0;
        alu_hang = 0; spur_en = 0; alu_lat = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_result", 32'(rsp_result), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_alu", {8'h0, alu_a, alu_b, 5'h0, alu_op}, 32'd0);
        check_eq("rst_alu_start", 32'(alu_start), 32'd0);
        check_eq("rst_op_count", 32'(op_count), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        m_reset();
        do_reset();

        // Single add from requester 0
        rsp_ready = 2'b11; req_valid = 2'b01; req_op = 6'o01;
        req_a = 16'h0012; req_b = 16'h0034; alu_lat = 1;
        step();
        req_valid = 2'b00;
        step();
        check_eq("add_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("add_result", 32'(rsp_result), 32'h0046);
        check_eq("add_err", 32'(rsp_err), 32'd0);
        check_eq("add_count", 32'(op_count), 32'd1);
        step();
        step();

        // Both requesters at once: round-robin order
        do_reset();
        rsp_ready = 2'b11; req_valid = 2'b11; req_op = 6'o44;
        req_a = 16'h03FF; req_b = 16'h05FF; alu_lat = 1;
        step();
        step();
        check_eq("rr0_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rr0_result", 32'(rsp_result), 32'hFE01);
        step();
        check_eq("rr_grant1", 32'(req_ready), 32'd2);
        step();
        step();
        check_eq("rr1_rsp_valid", 32'(rsp_valid), 32'd2);
        check_eq("rr1_result", 32'(rsp_result), 32'h000F);
        check_eq("rr1_count", 32'(op_count), 32'd2);
        step();
        check_eq("rr_grant0", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        step();

        // Illegal opcode from requester 1
        req_valid = 2'b10; req_op = 6'o61; rsp_ready = 2'b11;
        step();
        req_valid = 2'b00;
        check_eq("ill_rsp_valid", 32'(rsp_valid), 32'd2);
        check_eq("ill_err", 32'(rsp_err), 32'd1);
        check_eq("ill_result", 32'(rsp_result), 32'd0);
        check_eq("ill_alu_start", 32'(alu_start), 32'd0);
        check_eq("ill_count", 32'(op_count), 32'd2);
        step();

        // Response back-pressure
        req_valid = 2'b01; req_op = 6'o03; req_a = 16'h00A5; req_b = 16'h000F;
        rsp_ready = 2'b00; alu_lat = 2;
        step();
        step();
        step();
        check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp_result", 32'(rsp_result), 32'h00AA);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_hold_result", 32'(rsp_result), 32'h00AA);
            check_eq("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b10;
        step();
        check_eq("bp_wrong_ready", 32'(rsp_valid), 32'd1);
        rsp_ready = 2'b01;
        step();
        check_eq("bp_after_grant", 32'(req_ready), 32'd2);
        req_valid = 2'b00;
        step();

        // Asynchronous reset in the middle of ISSUE
        req_valid = 2'b01; req_op = 6'o01; req_a = 16'h0007; req_b = 16'h0009;
        rsp_ready = 2'b11; alu_lat = 6;
        step();
        req_valid = 2'b00;
        step();
        check_eq("ar_start_before", 32'(alu_start), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("ar_start", 32'(alu_start), 32'd0);
        check_eq("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_count", 32'(op_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
        req_valid = 2'b01; req_op = 6'o01; req_a = 16'h0001; req_b = 16'h0001; alu_lat = 1;
        step();
        req_valid = 2'b00;
        step();
        check_eq("ar_new_valid", 32'(rsp_valid), 32'd1);
        check_eq("ar_new_result", 32'(rsp_result), 32'h0002);
        step();

        // Random traffic
        spur_en = 1;
        for (int i = 0; i < 800; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_op    = 6'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            rsp_ready = 2'($urandom_range(0, 3));
            alu_lat   = $urandom_range(1, 3);
            step();
        end
        spur_en = 0;

`ifdef TINYALU_ARB_TIMEOUT_EN
        // ALU never answers: the timer aborts the operation
        do_reset();
        alu_hang = 1; alu_done = 1'b0; rsp_ready = 2'b00;
        req_valid = 2'b01; req_op = 6'o01; req_a = 16'h0003; req_b = 16'h0004;
        @(posedge clk);
        #1 req_valid = 2'b00;
        check_eq("to_start", 32'(alu_start), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check_eq("to_start_k", 32'(alu_start), (k < 4) ? 32'd1 : 32'd0);
        end
        check_eq("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("to_err", 32'(rsp_err), 32'd1);
        check_eq("to_result", 32'(rsp_result), 32'd0);
        check_eq("to_count", 32'(op_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
